// File: rtl/ext_sram_ctl.sv
// rtl/ext_sram_ctl.sv - 32-bit word requests to halfword cycles on a 16-bit multiplexed external SRAM bus
//
// Purpose: accepts one 32-bit read or write at a time. Each word becomes at most
// two halfword phases, LO (addr+0) then HI (addr+2). A phase is skipped when none
// of its bytes is selected. Address and data share the 16-bit bus. The low address
// half is latched with ale0 and the high half with ale1. The ale1 cycle can be
// skipped when the external latch already holds the right high address. Every
// output is a flop, so the bus strobes change only on the rising clock edge.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   stb, i_rw, i_addr,      request from the core, sampled only while idle
//   i_sel, i_dtw
//   ack, busy, dtr          one-cycle completion pulse, busy flag, read data
//   din, dout, isout        external bus in/out and output enable
//   ale0, ale1              low/high address latch strobes
//   we, oe, ble, bhe        write/read strobes, low/high byte enables
module ext_sram_ctl #(
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          LAZY_LATCH  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stb,
  input  logic        i_rw,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_dtw,
  output logic        ack,
  output logic        busy,
  output logic [31:0] dtr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        isout,
  output logic        ale0,
  output logic        ale1,
  output logic        we,
  output logic        oe,
  output logic        ble,
  output logic        bhe
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AL0  = 3'd1;
  localparam logic [2:0] S_AL1  = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [2:0] WS = 3'(WAIT_STATES);
  // With no wait states the strobe phase is the single T3 cycle.
  localparam logic [2:0] S_FIRST = (WAIT_STATES == 0) ? S_T3 : S_TW;

  logic [2:0]  state, state_d;
  logic [29:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dtw_q, dtw_d;
  logic        phase_q, phase_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        hi_valid_q;
  logic [14:0] hi_addr_q;

  logic        accept;
  logic        skip_al1;
  logic [1:0]  cur_sel;

  logic [15:0] dout_d;
  logic        isout_d, ale0_d, ale1_d, we_d, oe_d, ble_d, bhe_d, ack_d, busy_d;
  logic [31:0] dtr_d;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^i_addr[1:0];

  assign accept = (state == S_IDLE) && stb;

  // The high latch already holds this address in two cases. The first is a HI
  // phase that follows a LO phase of the same word, because that LO phase just
  // latched it. The second is a lazy hit on the stored high address.
  assign skip_al1 = (phase_q && (sel_q[1:0] != 2'b00)) ||
                    (LAZY_LATCH && hi_valid_q && (addr_q[29:15] == hi_addr_q));

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    rw_d    = rw_q;
    sel_d   = sel_q;
    dtw_d   = dtw_q;
    phase_d = phase_q;
    wcnt_d  = wcnt_q;
    case (state)
      S_IDLE: begin
        if (stb) begin
          addr_d  = i_addr[31:2];
          rw_d    = i_rw;
          sel_d   = i_sel;
          dtw_d   = i_dtw;
          // Start directly at HI when no byte of the LO half is selected.
          phase_d = (i_sel[1:0] == 2'b00);
          state_d = (i_sel == 4'b0000) ? S_DONE : S_AL0;
        end
      end
      S_AL0:   state_d = skip_al1 ? S_FIRST : S_AL1;
      S_AL1:   state_d = S_FIRST;
      S_TW: begin
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) begin
          state_d = S_T3;
        end
      end
      S_T3: begin
        if (!phase_q && (sel_q[3:2] != 2'b00)) begin
          phase_d = 1'b1;
          state_d = S_AL0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_TW) && (state != S_TW)) begin
      wcnt_d = WS;
    end
  end

  // Outputs are decoded from the next state and registered, so each strobe
  // lines up exactly with the cycle its state occupies.
  always_comb begin
    dout_d  = 16'h0000;
    isout_d = 1'b0;
    ale0_d  = 1'b0;
    ale1_d  = 1'b0;
    we_d    = 1'b0;
    oe_d    = 1'b0;
    ble_d   = 1'b0;
    bhe_d   = 1'b0;
    ack_d   = 1'b0;
    busy_d  = (state_d != S_IDLE);
    cur_sel = phase_d ? sel_d[3:2] : sel_d[1:0];
    case (state_d)
      S_AL0: begin
        dout_d  = {addr_d[14:0], phase_d};
        isout_d = 1'b1;
        ale0_d  = 1'b1;
      end
      S_AL1: begin
        dout_d  = {1'b0, addr_d[29:15]};
        isout_d = 1'b1;
        ale1_d  = 1'b1;
      end
      S_TW, S_T3: begin
        ble_d = cur_sel[0];
        bhe_d = cur_sel[1];
        if (rw_d) begin
          isout_d = 1'b1;
          we_d    = 1'b1;
          dout_d  = phase_d ? dtw_d[31:16] : dtw_d[15:0];
        end else begin
          oe_d = 1'b1;
        end
      end
      S_DONE:  ack_d = 1'b1;
      default: ;
    endcase
  end

  // Read data is cleared on accept. Each T3 then fills only the selected bytes
  // of its own phase.
  always_comb begin
    dtr_d = dtr;
    if (accept) begin
      dtr_d = 32'h0000_0000;
    end else if ((state == S_T3) && !rw_q) begin
      if (phase_q) begin
        if (sel_q[2]) dtr_d[23:16] = din[7:0];
        if (sel_q[3]) dtr_d[31:24] = din[15:8];
      end else begin
        if (sel_q[0]) dtr_d[7:0]   = din[7:0];
        if (sel_q[1]) dtr_d[15:8]  = din[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      sel_q      <= '0;
      dtw_q      <= '0;
      phase_q    <= 1'b0;
      wcnt_q     <= '0;
      hi_valid_q <= 1'b0;
      hi_addr_q  <= '0;
      dout       <= '0;
      isout      <= 1'b0;
      ale0       <= 1'b0;
      ale1       <= 1'b0;
      we         <= 1'b0;
      oe         <= 1'b0;
      ble        <= 1'b0;
      bhe        <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      dtr        <= '0;
    end else begin
      state   <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      sel_q   <= sel_d;
      dtw_q   <= dtw_d;
      phase_q <= phase_d;
      wcnt_q  <= wcnt_d;
      if (state == S_AL1) begin
        hi_addr_q  <= addr_q[29:15];
        hi_valid_q <= 1'b1;
      end
      dout    <= dout_d;
      isout   <= isout_d;
      ale0    <= ale0_d;
      ale1    <= ale1_d;
      we      <= we_d;
      oe      <= oe_d;
      ble     <= ble_d;
      bhe     <= bhe_d;
      ack     <= ack_d;
      busy    <= busy_d;
      dtr     <= dtr_d;
    end
  end

endmodule

// File: tb/tb_ext_sram_ctl.sv
// tb/tb_ext_sram_ctl.sv - directed and randomized cycle-trace bench for ext_sram_ctl
module tb_ext_sram_ctl;

  localparam int W_STATES = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stb;
  logic        i_rw;
  logic [31:0] i_addr;
  logic [3:0]  i_sel;
  logic [31:0] i_dtw;
  logic        ack;
  logic        busy;
  logic [31:0] dtr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        isout, ale0, ale1, we, oe, ble, bhe;

  always #5 clk = ~clk;

  ext_sram_ctl #(.WAIT_STATES(W_STATES), .LAZY_LATCH(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .stb(stb), .i_rw(i_rw), .i_addr(i_addr),
    .i_sel(i_sel), .i_dtw(i_dtw), .ack(ack), .busy(busy), .dtr(dtr),
    .din(din), .dout(dout), .isout(isout), .ale0(ale0), .ale1(ale1),
    .we(we), .oe(oe), .ble(ble), .bhe(bhe)
  );

  int checks   = 0;
  int failures = 0;

  // Model of the external high-address latch contents.
  bit          m_valid = 1'b0;
  logic [14:0] m_hi    = '0;

  typedef struct packed {
    logic [15:0] dout;
    logic        isout, ale0, ale1, we, oe, ble, bhe, ack;
    logic [15:0] din;
  } cyc_t;

  cyc_t trace[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected bus cycles for one request. Each selected halfword gets ale0, then
  // ale1 unless the latch already holds addr[31:17], then W+1 strobe cycles.
  // The trace ends with one ack cycle.
  task automatic build(input bit rw, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] dtw, input logic [15:0] din_lo,
                       input logic [15:0] din_hi, output logic [31:0] exp_dtr);
    cyc_t        c;
    logic [1:0]  s;
    logic [15:0] dv;
    trace.delete();
    exp_dtr = '0;
    for (int ph = 0; ph < 2; ph++) begin
      s  = (ph == 0) ? sel[1:0] : sel[3:2];
      dv = (ph == 0) ? din_lo : din_hi;
      if (s != 2'b00) begin
        c = '0; c.dout = {addr[16:2], ph[0]}; c.isout = 1'b1; c.ale0 = 1'b1;
        trace.push_back(c);
        if (!(m_valid && (m_hi == addr[31:17]))) begin
          c = '0; c.dout = {1'b0, addr[31:17]}; c.isout = 1'b1; c.ale1 = 1'b1;
          trace.push_back(c);
          m_valid = 1'b1;
          m_hi    = addr[31:17];
        end
        for (int t = 0; t <= W_STATES; t++) begin
          c = '0; c.ble = s[0]; c.bhe = s[1]; c.we = rw; c.oe = !rw; c.isout = rw;
          c.dout = rw ? ((ph == 0) ? dtw[15:0] : dtw[31:16]) : 16'h0000;
          c.din  = dv;
          trace.push_back(c);
        end
        if (!rw) begin
          if (s[0]) exp_dtr[ph*16 +: 8]     = dv[7:0];
          if (s[1]) exp_dtr[ph*16 + 8 +: 8] = dv[15:8];
        end
      end
    end
    c = '0; c.ack = 1'b1;
    trace.push_back(c);
  endtask

  task automatic run(input string tag, input bit rw, input logic [31:0] addr,
                     input logic [3:0] sel, input logic [31:0] dtw,
                     input logic [15:0] dlo, input logic [15:0] dhi, input int abort_at);
    logic [31:0] exp_dtr;
    logic [23:0] exp_bus, obs_bus;
    build(rw, addr, sel, dtw, dlo, dhi, exp_dtr);
    @(negedge clk);
    stb = 1'b1; i_rw = rw; i_addr = addr; i_sel = sel; i_dtw = dtw;
    @(posedge clk);
    for (int k = 0; k < trace.size(); k++) begin
      @(negedge clk);
      exp_bus = {trace[k].dout, trace[k].isout, trace[k].ale0, trace[k].ale1, trace[k].we,
                 trace[k].oe, trace[k].ble, trace[k].bhe, trace[k].ack};
      obs_bus = {dout, isout, ale0, ale1, we, oe, ble, bhe, ack};
      chk($sformatf("%s bus[%0d]", tag, k), 32'(obs_bus), 32'(exp_bus));
      chk($sformatf("%s busy[%0d]", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s excl[%0d]", tag, k), 32'($countones({ale0, ale1, we, oe}) <= 1), 32'd1);
      if (trace[k].ack) chk($sformatf("%s dtr", tag), dtr, exp_dtr);
      // The request inputs are noise while busy; stb must be ignored then.
      din    = trace[k].din;
      stb    = 1'($urandom);
      i_rw   = 1'($urandom);
      i_addr = $urandom;
      i_sel  = 4'($urandom);
      i_dtw  = $urandom;
      if (k == abort_at) begin
        reset_n = 1'b0;
        stb     = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk($sformatf("%s abort", tag), 32'({we, isout, busy, ack, oe, ale0, ale1}), 32'd0);
        m_valid = 1'b0;
        m_hi    = '0;
        return;
      end
    end
    @(negedge clk);
    stb = 1'b0;
    chk($sformatf("%s idle", tag), 32'({ack, busy}), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    reset_n = 1'b0; stb = 1'b0; i_rw = 1'b0; i_addr = '0; i_sel = '0; i_dtw = '0; din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", 32'({ack, busy, isout, ale0, ale1, we, oe, ble, bhe}), 32'd0);
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset dtr", dtr, 32'd0);
    reset_n = 1'b1;

    run("rd_full", 1'b0, 32'h0002_0000, 4'hF, 32'h0, 16'hBEEF, 16'hDEAD, -1);
    chk("rd_full const", dtr, 32'hDEADBEEF);
    run("rd_lazy", 1'b0, 32'h0002_0000, 4'hF, 32'h0, 16'h1357, 16'h2468, -1);
    chk("rd_lazy const", dtr, 32'h24681357);
    run("wr_hi", 1'b1, 32'h0000_0010, 4'b1100, 32'h12345678, 16'h0, 16'h0, -1);
    run("rd_b0", 1'b0, 32'h0000_0100, 4'b0001, 32'h0, 16'hAB77, 16'hFFFF, -1);
    chk("rd_b0 const", dtr, 32'h0000_0077);
    run("sel0", 1'b1, 32'h0000_0200, 4'b0000, 32'hFFFF_FFFF, 16'h0, 16'h0, -1);
    run("abort", 1'b1, 32'h0004_0000, 4'hF, 32'hCAFEF00D, 16'h0, 16'h0, 2);
    run("after_abort", 1'b1, 32'h0004_0000, 4'hF, 32'hCAFEF00D, 16'h0, 16'h0, -1);

    for (int n = 0; n < 40; n++) begin
      a = {15'($urandom_range(0, 2)), 17'($urandom)};
      run($sformatf("rnd%0d", n), 1'($urandom), a, 4'($urandom), $urandom,
          16'($urandom), 16'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
